// File: rtl/aes_encrypt_iterative_pkg.sv
// +----------------------------------------------------------------------+
// | aes_pkg: AES-128 constants, S-box table and GF(2^8) column mixing.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

  localparam int NR    = 10;
  localparam int BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // col[31:24] is row 0 of the column
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_encrypt_iterative_if.sv
// +----------------------------------------------------------------------+
// | aes_encrypt_iterative_if: plaintext/key input and ciphertext output. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface aes_encrypt_iterative_if;
  import aes_pkg::*;

  localparam int KS_W = BLK_W * (NR + 1);

  logic              in_valid;
  logic              in_ready;
  logic [0:BLK_W-1]  in_block;
  logic [0:KS_W-1]   key_schedule;
  logic              out_valid;
  logic              out_ready;
  logic [0:BLK_W-1]  out_block;

  modport slave (
    input  in_valid, in_block, key_schedule, out_ready,
    output in_ready, out_valid, out_block
  );

  modport master (
    output in_valid, in_block, key_schedule, out_ready,
    input  in_ready, out_valid, out_block
  );

endinterface

`default_nettype wire

// File: rtl/aes_encrypt_iterative_round.sv
// +----------------------------------------------------------------------+
// | aes_round: one combinational AES round, MixColumns skipped on final. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module aes_round
  import aes_pkg::*;
(
  input  logic [0:BLK_W-1] state_i,
  input  logic [0:BLK_W-1] round_key_i,
  input  logic             final_round_i,
  output logic [0:BLK_W-1] state_o
);

  logic [7:0]       sb_w [16];
  logic [0:BLK_W-1] sr_w;
  logic [0:BLK_W-1] mc_w;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb_w[i] = SBOX[state_i[8*i +: 8]];
    end
  end

  // Byte index is 4*col + row; row r rotates left by r columns
  always_comb begin
    sr_w = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_w[8*(4*c+r) +: 8] = sb_w[4*((c+r)%4) + r];
      end
    end
  end

  always_comb begin
    mc_w = '0;
    for (int c = 0; c < 4; c++) begin
      mc_w[32*c +: 32] = mix_column(sr_w[32*c +: 32]);
    end
  end

  assign state_o = (final_round_i ? sr_w : mc_w) ^ round_key_i;

endmodule

`default_nettype wire

// File: rtl/aes_encrypt_iterative.sv
// +----------------------------------------------------------------------+
// | aes_encrypt_iterative: AES-128 encryptor, one round per clock.       |
// | AES_KEY_LATCH_EN: capture key schedule at accept. Rev 1.0            |
// +----------------------------------------------------------------------+
`default_nettype none

module aes_encrypt_iterative
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  aes_encrypt_iterative_if.slave bus
);

  localparam int KS_W = BLK_W * (NR + 1);

  if (NR != 10) begin : g_nr_check
    $error("aes_encrypt_iterative: NR must be 10");
  end

  aes_fsm_t         fsm_q, fsm_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [0:BLK_W-1] state_q, state_d;
  logic [0:BLK_W-1] out_block_q, out_block_d;
  logic             in_ready_q, out_valid_q;
  logic [0:BLK_W-1] rk_w;
  logic [0:BLK_W-1] round_w;
  logic             final_w;

`ifdef AES_KEY_LATCH_EN
  logic [0:KS_W-1] key_q;

  always_ff @(posedge clk) begin
    if (fsm_q == IDLE && bus.in_valid) begin
      key_q <= bus.key_schedule;
    end
  end

  assign rk_w = key_q[BLK_W*int'(rnd_q) +: BLK_W];
`else
  assign rk_w = bus.key_schedule[BLK_W*int'(rnd_q) +: BLK_W];
`endif

  assign final_w = (rnd_q == 4'(NR));

  aes_round u_round (
    .state_i       (state_q),
    .round_key_i   (rk_w),
    .final_round_i (final_w),
    .state_o       (round_w)
  );

  always_comb begin
    fsm_d       = fsm_q;
    rnd_d       = rnd_q;
    state_d     = state_q;
    out_block_d = out_block_q;
    case (fsm_q)
      IDLE: begin
        // Initial AddRoundKey always uses the live rk[0]
        if (bus.in_valid) begin
          state_d = bus.in_block ^ bus.key_schedule[0:BLK_W-1];
          rnd_d   = 4'd1;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = round_w;
        if (final_w) begin
          out_block_d = round_w;
          rnd_d       = 4'd0;
          fsm_d       = DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= IDLE;
      rnd_q       <= 4'd0;
      state_q     <= '0;
      out_block_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      rnd_q       <= rnd_d;
      state_q     <= state_d;
      out_block_q <= out_block_d;
      in_ready_q  <= (fsm_d == IDLE);
      out_valid_q <= (fsm_d == DONE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_block = out_block_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_encrypt_iterative.sv
// +----------------------------------------------------------------------+
// | tb_aes_encrypt_iterative: scoreboard bench, FIPS-197 vectors.        |
// | Define AES_KEY_LATCH_EN to also test key latching. Rev 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_aes_encrypt_iterative;
  import aes_pkg::*;

  localparam int KS_W = BLK_W * (NR + 1);

  localparam logic [0:2047] TB_SBOX = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  aes_encrypt_iterative_if bus();

  aes_encrypt_iterative #(.NR(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [127:0] exp_q [$];
  int           acc_q [$];
  logic         prev_ov = 1'b0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] b);
    return TB_SBOX[8*int'(b) +: 8];
  endfunction

  // Standard AES-128 key expansion, rk r at bits [128r +: 128]
  function automatic logic [0:KS_W-1] expand(input logic [127:0] key);
    logic [31:0]     w [44];
    logic [31:0]     t;
    logic [7:0]      rc;
    logic [0:KS_W-1] ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ks[32*i +: 32] = w[i];
    return ks;
  endfunction

  // Monitor: latency on out_valid rise, ciphertext on handshake
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      acc_q.delete();
      prev_ov <= 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
      if (bus.out_valid && !prev_ov) begin
        if (acc_q.size() == 0) fail_now("spurious out_valid");
        else check("latency", 128'(cyc - acc_q.pop_front()), 128'd10);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected out_block handshake");
        else check("out_block", bus.out_block, exp_q.pop_front());
      end
      prev_ov <= bus.out_valid;
    end
  end

`ifndef AES_KEY_LATCH_EN
  logic            ks_hold = 1'b0;
  logic [0:KS_W-1] ks_ref  = '0;

  always @(negedge clk) begin
    if (ks_hold) assert (bus.key_schedule == ks_ref) else $error("key_schedule changed while engine busy");
    if (reset) ks_hold <= 1'b0;
    else if (bus.in_valid && bus.in_ready) begin
      ks_hold <= 1'b1;
      ks_ref  <= bus.key_schedule;
    end else if (bus.out_valid) ks_hold <= 1'b0;
  end
`endif

  // Waits until the engine is idle or finishing, then offers one block
  task automatic send(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    @(negedge clk);
    for (int k = 0; k < 40 && !(bus.in_ready || bus.out_valid); k++) @(negedge clk);
    @(posedge clk); #1;
    bus.in_block     = pt;
    bus.key_schedule = expand(key);
    bus.in_valid     = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        exp_q.push_back(exp);
        acc = cyc + 1;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (!got) fail_now("accept timeout");
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) fail_now("drain timeout");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2;
    bus.in_valid     = 1'b0;
    bus.in_block     = '0;
    bus.key_schedule = '0;
    bus.out_ready    = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 128'(bus.in_ready), 128'd1);
    check("reset out_valid", 128'(bus.out_valid), 128'd0);
    check("reset out_block", bus.out_block, 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    send(PT1, KEY1, CT1, a0);
    drain();
    send(PT2, KEY2, CT2, a0);
    drain();

    // Back-pressure with ignored in_valid pulses
    bus.out_ready = 1'b0;
    send(PT1, KEY1, CT1, a0);
    for (int k = 0; k < 40 && !bus.out_valid; k++) @(negedge clk);
    check("bp out_valid rise", 128'(bus.out_valid), 128'd1);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      bus.in_valid = (k % 2 == 0) && (k < 19);
      bus.in_block = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("bp out_valid", 128'(bus.out_valid), 128'd1);
      check("bp in_ready", 128'(bus.in_ready), 128'd0);
      check("bp out_block", bus.out_block, CT1);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp release in_ready", 128'(bus.in_ready), 128'd1);
    check("bp release out_valid", 128'(bus.out_valid), 128'd0);
    check("bp out_block retained", bus.out_block, CT1);
    drain();

    // Reset in the middle of a transaction
    send(PT1, KEY1, CT1, a0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort in_ready", 128'(bus.in_ready), 128'd1);
    check("abort out_valid", 128'(bus.out_valid), 128'd0);
    check("abort out_block", bus.out_block, 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (15) @(negedge clk);
    send(PT2, KEY2, CT2, a0);
    drain();

    // Back-to-back 1,2,1
    send(PT1, KEY1, CT1, a0);
    send(PT2, KEY2, CT2, a1);
    send(PT1, KEY1, CT1, a2);
    check("b2b spacing 1-2", 128'(a1 - a0), 128'd12);
    check("b2b spacing 2-3", 128'(a2 - a1), 128'd12);
    drain();

`ifdef AES_KEY_LATCH_EN
    send(PT1, KEY1, CT1, a0);
    for (int k = 0; k < 12; k++) begin
      for (int w = 0; w < 44; w++) bus.key_schedule[32*w +: 32] = $urandom;
      @(posedge clk); #1;
    end
    drain();
`endif

    repeat (3) @(negedge clk);
    check("scoreboard empty", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
